// File: rtl/retire_map_unit_pkg.sv
// Shared sizing and types for the commit-side rename map and its free-return queue.
package retire_map_unit_pkg;

  localparam int DISPATCH_WIDTH       = 2;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int FREE_FIFO_DEPTH      = 8;
  localparam int ARCH_REGS            = 32;
  localparam int FIFO_AW              = $clog2(FREE_FIFO_DEPTH);
  localparam int FIFO_CW              = FIFO_AW + 1;

  typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_t;
  typedef logic [4:0]                      arch_t;
  typedef logic [FIFO_CW-1:0]              fcnt_t;

  function automatic fcnt_t min_cnt(input fcnt_t a, input fcnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/retire_map_unit_free_return_fifo.sv
// Multi-push / multi-pop queue of superseded physical registers.
// Pushes arrive already compacted (slots 0..push_cnt-1); pops take every presented lane.
module free_return_fifo
  import retire_map_unit_pkg::*;
#(
  parameter int LANES = DISPATCH_WIDTH,
  parameter int DEPTH = FREE_FIFO_DEPTH,
  parameter int W     = PHYS_REGS_ADDR_WIDTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CW-1:0]          i_push_cnt,
  input  logic [LANES-1:0][W-1:0] i_push_data,
  input  logic                   i_pop,
  output logic [LANES-1:0]       o_vld,
  output logic [LANES-1:0][W-1:0] o_data,
  output logic [CW-1:0]          o_count,
  output logic                   o_drop
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_pops;
  logic [CW-1:0] w_space;
  logic [CW-1:0] w_accept;

  // Same-cycle pops free room for same-cycle pushes.
  always_comb begin
    w_pops = '0;
    if (i_pop) begin
      w_pops = (r_count < CW'(LANES)) ? r_count : CW'(LANES);
    end
    w_space  = CW'(DEPTH) - r_count + w_pops;
    w_accept = (i_push_cnt < w_space) ? i_push_cnt : w_space;
  end

  assign o_drop  = (i_push_cnt > w_space);
  assign o_count = r_count;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      o_vld[k]  = (r_count > CW'(k));
      o_data[k] = r_mem[r_head + AW'(k)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pops[AW-1:0];
      r_tail  <= r_tail + w_accept[AW-1:0];
      r_count <= r_count + w_accept - w_pops;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < LANES; s++) begin
      if (CW'(s) < w_accept) begin
        r_mem[r_tail + AW'(s)] <= i_push_data[s];
      end
    end
  end

endmodule

// File: rtl/retire_map_unit.sv
// Commit-side rename map: applies in-order commits to the architectural map,
// queues superseded physical registers for the freelist, and counts retirements.
module retire_map_unit
  import retire_map_unit_pkg::*;
(
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [DISPATCH_WIDTH-1:0]                         commit_en,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd,
  input  logic [DISPATCH_WIDTH-1:0][4:0]                    commit_arch_rd,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                   commit_pc,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                   commit_instr,
  output logic                                              commit_stall,
  output logic [DISPATCH_WIDTH-1:0]                         free_valid,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] free_phys,
  input  logic                                              free_ready,
  output logic [ARCH_REGS-1:0][PHYS_REGS_ADDR_WIDTH-1:0]    crat_phys,
  output logic [63:0]                                       instret,
  output logic                                              overflow_err
);

  logic [ARCH_REGS-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      r_crat;
  logic [63:0]                                         r_instret;
  logic                                                r_ovf;

  logic [ARCH_REGS-1:0][PHYS_REGS_ADDR_WIDTH-1:0]      w_map;
  fcnt_t                                               w_push_cnt;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] w_push_data;
  fcnt_t                                               w_count;
  logic                                                w_drop;
  logic                                                w_unused_dbg;

  assign w_unused_dbg = ^{commit_pc, commit_instr};

  // Lanes walk oldest to youngest against a running copy of the map, so a
  // younger lane to the same arch reg frees the older lane's phys_rd.
  always_comb begin
    w_map       = r_crat;
    w_push_cnt  = '0;
    w_push_data = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (commit_en[l] && (commit_arch_rd[l] != '0)) begin
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
          if (w_push_cnt == fcnt_t'(s)) begin
            w_push_data[s] = w_map[commit_arch_rd[l]];
          end
        end
        w_map[commit_arch_rd[l]] = commit_phys_rd[l];
        w_push_cnt               = w_push_cnt + fcnt_t'(1);
      end
    end
  end

  free_return_fifo #(
    .LANES (DISPATCH_WIDTH),
    .DEPTH (FREE_FIFO_DEPTH),
    .W     (PHYS_REGS_ADDR_WIDTH)
  ) u_free_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push_cnt  (w_push_cnt),
    .i_push_data (w_push_data),
    .i_pop       (free_ready),
    .o_vld       (free_valid),
    .o_data      (free_phys),
    .o_count     (w_count),
    .o_drop      (w_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_crat[i] <= PHYS_REGS_ADDR_WIDTH'(i);
      end
      r_instret <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_crat    <= w_map;
      r_instret <= r_instret + 64'($countones(commit_en));
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Stall depends only on the registered occupancy, never on commit inputs.
  assign commit_stall = (fcnt_t'(FREE_FIFO_DEPTH) - w_count) < fcnt_t'(DISPATCH_WIDTH);
  assign crat_phys    = r_crat;
  assign instret      = r_instret;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_retire_map_unit.sv
// Directed and randomized bench for retire_map_unit against a queue-based reference model.
module tb_retire_map_unit;
  import retire_map_unit_pkg::*;

  localparam int PW    = PHYS_REGS_ADDR_WIDTH;
  localparam int DEPTH = FREE_FIFO_DEPTH;

  logic                 clk;
  logic                 rst;
  logic [1:0]           commit_en;
  logic [1:0][PW-1:0]   commit_phys_rd;
  logic [1:0][4:0]      commit_arch_rd;
  logic [1:0][31:0]     commit_pc;
  logic [1:0][31:0]     commit_instr;
  logic                 commit_stall;
  logic [1:0]           free_valid;
  logic [1:0][PW-1:0]   free_phys;
  logic                 free_ready;
  logic [31:0][PW-1:0]  crat_phys;
  logic [63:0]          instret;
  logic                 overflow_err;

  int checks = 0;
  int errors = 0;

  int              m_crat [32];
  int              m_q [$];
  longint unsigned m_instret;
  bit              m_ovf;

  retire_map_unit dut (
    .clk            (clk),
    .rst            (rst),
    .commit_en      (commit_en),
    .commit_phys_rd (commit_phys_rd),
    .commit_arch_rd (commit_arch_rd),
    .commit_pc      (commit_pc),
    .commit_instr   (commit_instr),
    .commit_stall   (commit_stall),
    .free_valid     (free_valid),
    .free_phys      (free_phys),
    .free_ready     (free_ready),
    .crat_phys      (crat_phys),
    .instret        (instret),
    .overflow_err   (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_crat[i] = i;
    m_q.delete();
    m_instret = 0;
    m_ovf     = 1'b0;
  endtask

  // Occupancy-level model: pop first, then apply lanes in age order, then enqueue.
  task automatic model_step();
    int pops;
    int pend [$];
    pops = 0;
    if (free_ready) pops = (m_q.size() < 2) ? m_q.size() : 2;
    for (int i = 0; i < pops; i++) void'(m_q.pop_front());
    for (int l = 0; l < 2; l++) begin
      if (commit_en[l] && commit_arch_rd[l] != 0) begin
        pend.push_back(m_crat[commit_arch_rd[l]]);
        m_crat[commit_arch_rd[l]] = int'(commit_phys_rd[l]);
      end
    end
    foreach (pend[i]) begin
      if (m_q.size() < DEPTH) m_q.push_back(pend[i]);
      else m_ovf = 1'b1;
    end
    m_instret += longint'($countones(commit_en));
  endtask

  task automatic check_all(input string tag);
    logic [31:0][PW-1:0] ec;
    logic [1:0]          ev;
    for (int i = 0; i < 32; i++) ec[i] = PW'(m_crat[i]);
    check($sformatf("%s.crat", tag), crat_phys, ec);
    for (int k = 0; k < 2; k++) begin
      ev[k] = (m_q.size() > k);
      if (ev[k]) check($sformatf("%s.free_phys%0d", tag, k), free_phys[k], m_q[k]);
    end
    check($sformatf("%s.free_valid", tag), free_valid, ev);
    check($sformatf("%s.stall", tag), commit_stall, ((DEPTH - m_q.size()) < 2));
    check($sformatf("%s.instret", tag), instret, m_instret);
    check($sformatf("%s.ovf", tag), overflow_err, m_ovf);
  endtask

  task automatic step(input string tag, input logic [1:0] en,
                      input logic [4:0] a0, input logic [PW-1:0] p0,
                      input logic [4:0] a1, input logic [PW-1:0] p1,
                      input logic rdy);
    commit_en         = en;
    commit_arch_rd[0] = a0;
    commit_phys_rd[0] = p0;
    commit_arch_rd[1] = a1;
    commit_phys_rd[1] = p1;
    commit_pc         = {$urandom, $urandom};
    commit_instr      = {$urandom, $urandom};
    free_ready        = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    commit_en  = '0;
    free_ready = 1'b0;
    rst        = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all({tag, ".release"});
  endtask

  initial begin
    logic [1:0] en;
    rst            = 1'b1;
    commit_en      = '0;
    commit_phys_rd = '0;
    commit_arch_rd = '0;
    commit_pc      = '0;
    commit_instr   = '0;
    free_ready     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.crat7", crat_phys[7], 7);
    check("reset.free_valid", free_valid, 2'b00);
    check("reset.stall", commit_stall, 1'b0);
    check("reset.instret", instret, 0);
    check("reset.ovf", overflow_err, 1'b0);

    step("single", 2'b01, 5'd5, 6'd40, 5'd0, 6'd0, 1'b1);
    check("single.crat5", crat_phys[5], 40);
    check("single.fv0", free_valid[0], 1'b1);
    check("single.fp0", free_phys[0], 5);
    check("single.instret", instret, 1);

    do_reset("rst1");
    step("samearch", 2'b11, 5'd3, 6'd33, 5'd3, 6'd34, 1'b0);
    check("samearch.fv", free_valid, 2'b11);
    check("samearch.fp0", free_phys[0], 3);
    check("samearch.fp1", free_phys[1], 33);
    check("samearch.crat3", crat_phys[3], 34);
    check("samearch.instret", instret, 2);

    do_reset("rst2");
    step("x0lane", 2'b11, 5'd0, 6'd0, 5'd9, 6'd50, 1'b0);
    check("x0lane.fv", free_valid, 2'b01);
    check("x0lane.fp0", free_phys[0], 9);
    check("x0lane.crat0", crat_phys[0], 0);
    check("x0lane.crat9", crat_phys[9], 50);
    check("x0lane.instret", instret, 2);

    do_reset("rst3");
    step("bp1", 2'b11, 5'd1, 6'd10, 5'd2, 6'd11, 1'b0);
    step("bp2", 2'b11, 5'd3, 6'd12, 5'd4, 6'd13, 1'b0);
    step("bp3", 2'b11, 5'd6, 6'd14, 5'd7, 6'd15, 1'b0);
    check("bp3.stall_low", commit_stall, 1'b0);
    step("bp4", 2'b11, 5'd8, 6'd16, 5'd10, 6'd17, 1'b0);
    check("bp4.stall_high", commit_stall, 1'b1);
    step("fullswap", 2'b11, 5'd11, 6'd18, 5'd12, 6'd19, 1'b1);
    check("fullswap.ovf", overflow_err, 1'b0);
    check("fullswap.fp0", free_phys[0], 3);
    step("ovf", 2'b01, 5'd20, 6'd60, 5'd0, 6'd0, 1'b0);
    check("ovf.flag", overflow_err, 1'b1);
    check("ovf.crat20", crat_phys[20], 60);
    step("drain1", 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1);
    check("drain1.stall", commit_stall, 1'b0);
    repeat (3) step("drain", 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1);
    check("drain.fv", free_valid, 2'b00);
    check("drain.ovf_sticky", overflow_err, 1'b1);

    do_reset("rst4");
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset("rst_mid");
      en = 2'($urandom_range(0, 3));
      if (((DEPTH - m_q.size()) < 2) && ($urandom_range(0, 7) != 0)) en = 2'b00;
      step("rand", en, 5'($urandom_range(0, 7)), PW'($urandom_range(0, 63)),
           5'($urandom_range(0, 7)), PW'($urandom_range(0, 63)),
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
